// File: rtl/ps2_key_decoder_if.sv
// Bundle between the PS/2 key decoder and its neighbours: raw pins in, event word,
// debug byte/strobe, error pulse and FSM state out.
interface ps2_key_decoder_if;
  // rx_strobe and frame_err are valid-only pulses with no ready: a consumer must take
  // rx_byte in the single cycle rx_strobe is high. ps2_key is level-held and its bit 10
  // toggles once per key event while bits 9:0 are already stable.
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic [7:0]  rx_byte;
  logic        rx_strobe;
  logic        frame_err;
  logic [1:0]  fsm_state;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output ps2_key,
    output rx_byte,
    output rx_strobe,
    output frame_err,
    output fsm_state
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  ps2_key,
    input  rx_byte,
    input  rx_strobe,
    input  frame_err,
    input  fsm_state
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises and filters the raw pins, frames 11-bit
// characters, and folds E0/F0/E1 prefixes into an 11-bit toggle-event key word.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 21632
) (
  input logic               clk_sys,
  input logic               reset_n,
  ps2_key_decoder_if.master bus
);

  localparam int FC_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Input conditioning
  logic            clk_s1_q, clk_s2_q;
  logic            dat_s1_q, dat_s2_q;
  logic            filt_q, filt_d;
  logic [FC_W-1:0] filt_cnt_q, filt_cnt_d;
  logic            fall_en;

  // Frame FSM
  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_strobe_q, rx_strobe_d;
  logic            frame_err_q, frame_err_d;
  logic            bad_frame;

  // Byte decoder
  logic            ext_q, ext_d;
  logic            rel_q, rel_d;
  logic [2:0]      skip_q, skip_d;
  logic [10:0]     key_q, key_d;
  logic            is_ctrl_byte;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= bus.ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= bus.ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // The filtered level only moves after FILTER_LEN consecutive samples of the new level.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FC_W'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FC_W'(1);
      end
    end
  end

  assign fall_en = filt_q & ~filt_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    to_cnt_d    = to_cnt_q;
    rx_byte_d   = rx_byte_q;
    rx_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    bad_frame   = 1'b0;

    case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (fall_en) begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (fall_en) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (fall_en) begin
          parity_d = dat_s2_q;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (fall_en) begin
          if (dat_s2_q && (^{shift_q, parity_q})) begin
            rx_byte_d   = shift_q;
            rx_strobe_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            bad_frame   = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A falling edge in the same cycle as expiry wins, so the frame survives.
    if (state_q != S_IDLE) begin
      if (fall_en) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        frame_err_d = 1'b1;
        state_d     = S_IDLE;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      rx_byte_q   <= 8'h00;
      rx_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      rx_byte_q   <= rx_byte_d;
      rx_strobe_q <= rx_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Keyboard housekeeping replies (ACK, BAT, echo, resend...) never become key events.
  always_comb begin
    is_ctrl_byte = 1'b0;
    case (rx_byte_q)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_ctrl_byte = 1'b1;
      default:                                       is_ctrl_byte = 1'b0;
    endcase
  end

  always_comb begin
    ext_d  = ext_q;
    rel_d  = rel_q;
    skip_d = skip_q;
    key_d  = key_q;

    if (rx_strobe_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (rx_byte_q)
          8'hE1: skip_d = 3'd7;
          8'hE0: ext_d  = 1'b1;
          8'hF0: rel_d  = 1'b1;
          default: begin
            if (ext_q || rel_q || !is_ctrl_byte) begin
              key_d = {~key_q[10], ~rel_q, ext_q, rx_byte_q};
              ext_d = 1'b0;
              rel_d = 1'b0;
            end
          end
        endcase
      end
    end

    if (bad_frame) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ext_q  <= 1'b0;
      rel_q  <= 1'b0;
      skip_q <= 3'd0;
      key_q  <= 11'h000;
    end else begin
      ext_q  <= ext_d;
      rel_q  <= rel_d;
      skip_q <= skip_d;
      key_q  <= key_d;
    end
  end

  assign bus.ps2_key   = key_q;
  assign bus.rx_byte   = rx_byte_q;
  assign bus.rx_strobe = rx_strobe_q;
  assign bus.frame_err = frame_err_q;
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, a key-event scoreboard
// and pulse counters checked against hand-computed values.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 600;
  localparam int HALF           = 40;
  localparam int GAP            = 100;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  initial begin
    repeat (100000) @(posedge clk_sys);
    $display("FAIL watchdog: got no finish, required finish within 100000 cycles");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int key_chg = 0;
  int last_strobe_cyc = 0;
  int last_key_cyc = 0;
  logic        mon_en = 1'b0;
  logic [10:0] prev_key = 11'h000;
  logic [10:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    cyc++;
    if (mon_en) begin
      if (bus.rx_strobe === 1'b1) begin
        strobe_cnt++;
        last_strobe_cyc = cyc;
      end
      if (bus.frame_err === 1'b1) err_cnt++;
      if (bus.ps2_key !== prev_key) begin
        key_chg++;
        last_key_cyc = cyc;
        if (exp_q.size() == 0) check_val("unexpected_key", 32'(bus.ps2_key), 32'(prev_key));
        else check_val("key_event", 32'(bus.ps2_key), 32'(exp_q.pop_front()));
        prev_key = bus.ps2_key;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b0;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    bus.ps2_data = 1'b1;
    wait_cyc(GAP);
  endtask

  // ---------------- stimulus ----------------
  int base_s, base_e, base_k;
  logic [7:0] e1_seq [8];

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    #2 reset_n = 1'b0;
    wait_cyc(5);
    check_val("rst_key",    32'(bus.ps2_key),   32'h000);
    check_val("rst_byte",   32'(bus.rx_byte),   32'h00);
    check_val("rst_strobe", 32'(bus.rx_strobe), 32'h0);
    check_val("rst_err",    32'(bus.frame_err), 32'h0);
    check_val("rst_state",  32'(bus.fsm_state), 32'h0);
    reset_n = 1'b1;
    wait_cyc(20);
    prev_key = bus.ps2_key;
    mon_en   = 1'b1;

    // A key press
    exp_q.push_back(11'h61C);
    send_frame(8'h1C, 1'b0);
    check_val("a_rx_byte", 32'(bus.rx_byte), 32'h1C);
    check_val("a_strobes", 32'(strobe_cnt), 32'd1);
    check_val("a_key", 32'(bus.ps2_key), 32'h61C);
    check_val("a_latency", 32'(last_key_cyc - last_strobe_cyc), 32'd1);

    // A key release
    exp_q.push_back(11'h01C);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_val("a_rel_strobes", 32'(strobe_cnt), 32'd3);
    check_val("a_rel_key", 32'(bus.ps2_key), 32'h01C);

    // Extended press then extended release
    exp_q.push_back(11'h775);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check_val("up_press_key", 32'(bus.ps2_key), 32'h775);
    exp_q.push_back(11'h175);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check_val("up_rel_key", 32'(bus.ps2_key), 32'h175);
    check_val("up_rel_byte", 32'(bus.rx_byte), 32'h75);

    // Parity error, then the same byte correctly framed
    base_s = strobe_cnt;
    base_e = err_cnt;
    send_frame(8'h29, 1'b1);
    check_val("par_err", 32'(err_cnt), 32'(base_e + 1));
    check_val("par_no_strobe", 32'(strobe_cnt), 32'(base_s));
    check_val("par_key_hold", 32'(bus.ps2_key), 32'h175);
    check_val("par_byte_hold", 32'(bus.rx_byte), 32'h75);
    exp_q.push_back(11'h629);
    send_frame(8'h29, 1'b0);
    check_val("space_key_lo", 32'(bus.ps2_key[9:0]), 32'h229);

    // Truncated frame left to time out
    base_e = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    bus.ps2_data = 1'b1;
    wait_cyc(TIMEOUT_CYCLES - 100);
    check_val("to_not_early", 32'(err_cnt), 32'(base_e));
    wait_cyc(200);
    check_val("to_err", 32'(err_cnt), 32'(base_e + 1));
    check_val("to_state_idle", 32'(bus.fsm_state), 32'h0);
    exp_q.push_back(11'h205);
    send_frame(8'h05, 1'b0);
    check_val("to_next_key", 32'(bus.ps2_key), 32'h205);
    check_val("to_next_byte", 32'(bus.rx_byte), 32'h05);

    // Pause/Break sequence swallowed, next key decoded normally
    e1_seq[0] = 8'hE1; e1_seq[1] = 8'h14; e1_seq[2] = 8'h77; e1_seq[3] = 8'hE1;
    e1_seq[4] = 8'hF0; e1_seq[5] = 8'h14; e1_seq[6] = 8'hF0; e1_seq[7] = 8'h77;
    base_k = key_chg;
    base_s = strobe_cnt;
    for (int i = 0; i < 8; i++) send_frame(e1_seq[i], 1'b0);
    check_val("e1_no_event", 32'(key_chg), 32'(base_k));
    check_val("e1_strobes", 32'(strobe_cnt), 32'(base_s + 8));
    exp_q.push_back(11'h616);
    send_frame(8'h16, 1'b0);
    check_val("e1_next_key", 32'(bus.ps2_key), 32'h616);

    // Short clock glitch must not register as an edge
    base_e = err_cnt;
    bus.ps2_clk = 1'b0;
    wait_cyc(3);
    bus.ps2_clk = 1'b1;
    wait_cyc(30);
    check_val("glitch_no_err", 32'(err_cnt), 32'(base_e));
    check_val("glitch_idle", 32'(bus.fsm_state), 32'h0);
    exp_q.push_back(11'h016);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h16, 1'b0);
    check_val("glitch_next_key", 32'(bus.ps2_key), 32'h016);

    // Reset in the middle of a frame
    exp_q.push_back(11'h000);
    base_s = strobe_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    reset_n = 1'b0;
    wait_cyc(3);
    check_val("mid_rst_state", 32'(bus.fsm_state), 32'h0);
    check_val("mid_rst_key", 32'(bus.ps2_key), 32'h000);
    check_val("mid_rst_byte", 32'(bus.rx_byte), 32'h00);
    bus.ps2_data = 1'b1;
    reset_n = 1'b1;
    wait_cyc(20);
    check_val("mid_rst_no_strobe", 32'(strobe_cnt), 32'(base_s));
    exp_q.push_back(11'h61C);
    send_frame(8'h1C, 1'b0);
    check_val("post_rst_key", 32'(bus.ps2_key), 32'h61C);

    check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
